spi_master_ctrl: RTL

Single-clock SPI master that issues the 10-bit command frames (2-bit opcode + 8-bit payload) understood by the SPI slave/RAM subsystem, and captures the 8-bit read-data reply from `miso`. It sits between a host-side request port and the slave's `mosi`/`ss_n`/`miso` pins. It shares the slave's `clk`, so no separate SCK is generated. It replaces testbench-driven stimulus with a synthesizable initiator that enforces the frame, turnaround and gap timing.

---
 rtl/spi_master_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// SPI command-frame initiator: sends a 10-bit {opcode,payload} frame MSB first,
// holds select through turnaround, and captures an 8-bit reply for opcode 11.
module spi_master_ctrl #(
  parameter int unsigned TURN = 2,
  parameter int unsigned GAP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] payload,
  input  logic       miso,
  output logic       mosi,
  output logic       ss_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_SHIFT, S_TURN, S_RECV, S_GAP
  } state_e;

  localparam logic [3:0] TURN_LAST = 4'(TURN - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);
  // Wraps to 4'hF when GAP==1; that branch is unreachable in that case.
  localparam logic [3:0] GAP_PRE   = 4'(GAP - 2);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [9:0] sr_q;
  logic       rd_q;
  logic       mosi_q, ss_n_q, busy_q, done_q, rx_valid_q;
  logic [7:0] rx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      rd_q       <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            sr_q    <= {cmd, payload};
            rd_q    <= &cmd;
            cnt_q   <= '0;
            ss_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            mosi_q  <= 1'b0;
            state_q <= S_SEL;
          end
        end
        S_SEL: begin
          mosi_q  <= sr_q[9];
          sr_q    <= {sr_q[8:0], 1'b0};
          cnt_q   <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt_q == 4'd9) begin
            mosi_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_TURN;
          end else begin
            mosi_q <= sr_q[9];
            sr_q   <= {sr_q[8:0], 1'b0};
            cnt_q  <= cnt_q + 4'd1;
          end
        end
        S_TURN: begin
          if (cnt_q == TURN_LAST) begin
            cnt_q <= '0;
            if (rd_q) begin
              state_q <= S_RECV;
            end else begin
              ss_n_q     <= 1'b1;
              done_q     <= (GAP == 1);
              rx_valid_q <= 1'b0;
              state_q    <= S_GAP;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_RECV: begin
          // Cycle 0 of RECV is slave latency; miso is only trusted afterwards.
          if (cnt_q != 4'd0) rx_q <= {rx_q[6:0], miso};
          if (cnt_q == 4'd8) begin
            cnt_q      <= '0;
            ss_n_q     <= 1'b1;
            done_q     <= (GAP == 1);
            rx_valid_q <= (GAP == 1);
            state_q    <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == GAP_PRE) begin
              done_q     <= 1'b1;
              rx_valid_q <= rd_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_q;
  assign rx_valid = rx_valid_q;

endmodule
